// File: rtl/divider_mem_ctrl_p_if.sv
// Bus bundle for divider_mem_ctrl_p: batch read input, divider lanes and the
// scratch-memory write channel. master = controller side, slave = environment side.
interface divider_mem_ctrl_p_if #(
    parameter int LANES = 8,
    parameter int DW    = 32,
    parameter int MEM_W = 128
);
    localparam int LPL    = MEM_W / DW;
    localparam int NLINES = (LANES + LPL - 1) / LPL;
    localparam int LW     = (NLINES > 1) ? $clog2(NLINES) : 1;

    logic                rd_data_rdy;
    logic [LANES*DW-1:0] rd_data;
    logic                div_start;
    logic [LANES*DW-1:0] div_operand;
    logic [LANES-1:0]    div_done;
    logic [LANES*DW-1:0] div_value;
    logic                wt_valid;
    logic                wt_ready;
    logic [LW-1:0]       wt_line;
    logic [MEM_W-1:0]    wt_data;

    modport master (
        input  rd_data_rdy, rd_data, div_done, div_value, wt_ready,
        output div_start, div_operand, wt_valid, wt_line, wt_data
    );

    modport slave (
        output rd_data_rdy, rd_data, div_done, div_value, wt_ready,
        input  div_start, div_operand, wt_valid, wt_line, wt_data
    );
endinterface

// File: rtl/divider_mem_ctrl_p.sv
// Lane controller: captures one operand batch, fans it out to LANES dividers, gathers
// quotients in any order and writes them back as MEM_W-wide lines. Option: DIV_TIMEOUT_EN.
module divider_mem_ctrl_p #(
    parameter int LANES  = 8,
    parameter int DW     = 32,
    parameter int MEM_W  = 128,
    parameter int WR_GAP = 2,
    parameter int TMO    = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    divider_mem_ctrl_p_if.master bus,
    output logic                 busy,
    output logic                 batch_done,
    output logic                 rd_overrun,
    output logic                 timeout_err
);
    localparam int LPL    = MEM_W / DW;
    localparam int NLINES = (LANES + LPL - 1) / LPL;
    localparam int LW     = (NLINES > 1) ? $clog2(NLINES) : 1;

    if (LANES < 1 || LPL < 1 || (MEM_W % DW) != 0) begin : g_bad_geometry
        $error("divider_mem_ctrl_p: illegal LANES/DW/MEM_W combination");
    end
    if (WR_GAP < 0 || WR_GAP > 15 || TMO < 1 || TMO > 1023) begin : g_bad_timing
        $error("divider_mem_ctrl_p: WR_GAP or TMO out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_WRITE, S_GAP, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [LANES-1:0]        mask;
    logic [LANES*DW-1:0]     operand_q;
    logic [LANES*DW-1:0]     result_q;
    logic [NLINES*MEM_W-1:0] result_pad;
    logic [LW-1:0]           line;
    logic [3:0]              gap_cnt;
    logic                    acc_pend;
    logic                    mask_full;
    logic                    last_line;
    logic                    gap_end;
    logic                    accept;
    logic                    tmo_hit;

    assign mask_full = &(mask | bus.div_done);
    assign last_line = (line == LW'(NLINES - 1));
    assign gap_end   = (gap_cnt == 4'(WR_GAP - 1));
    // A line accepted while frozen is remembered so it is neither re-offered nor lost.
    assign accept    = bus.wt_ready | acc_pend;

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (enable) begin
            unique case (state)
                S_IDLE:  if (bus.rd_data_rdy) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_WAIT;
                S_WAIT:  if (mask_full || tmo_hit) state_nxt = S_WRITE;
                S_WRITE: if (accept) begin
                    if (WR_GAP > 0)     state_nxt = S_GAP;
                    else if (last_line) state_nxt = S_DONE;
                    else                state_nxt = S_WRITE;
                end
                S_GAP:   if (gap_end) state_nxt = last_line ? S_DONE : S_WRITE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy          = (state != S_IDLE);
        batch_done    = (state == S_DONE) && enable;
        bus.div_start = (state == S_LOAD) && enable;
        bus.wt_valid  = (state == S_WRITE) && !acc_pend;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: result registers are reset (not left uninitialised like a RAM) because
        // wt_data exposes them directly and must read 0 out of reset.
        if (!reset) begin
            operand_q  <= '0;
            result_q   <= '0;
            mask       <= '0;
            line       <= '0;
            gap_cnt    <= '0;
            acc_pend   <= 1'b0;
            rd_overrun <= 1'b0;
        end else begin
            if (!enable && state == S_WRITE && bus.wt_ready) acc_pend <= 1'b1;
            if (enable) begin
                if (state != S_IDLE && bus.rd_data_rdy) rd_overrun <= 1'b1;
                unique case (state)
                    S_IDLE: if (bus.rd_data_rdy) begin
                        operand_q  <= bus.rd_data;
                        result_q   <= '0;
                        mask       <= '0;
                        line       <= '0;
                        rd_overrun <= 1'b0;
                    end
                    S_WAIT: begin
                        for (int i = 0; i < LANES; i++) begin
                            if (bus.div_done[i] && !mask[i])
                                result_q[i*DW +: DW] <= bus.div_value[i*DW +: DW];
                        end
                        mask <= mask | bus.div_done;
                    end
                    S_WRITE: if (accept) begin
                        acc_pend <= 1'b0;
                        gap_cnt  <= '0;
                        if (WR_GAP == 0 && !last_line) line <= line + LW'(1);
                    end
                    S_GAP: begin
                        if (gap_end) begin
                            gap_cnt <= '0;
                            if (!last_line) line <= line + LW'(1);
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef DIV_TIMEOUT_EN
    logic [9:0] tmo_cnt;

    assign tmo_hit = (state == S_WAIT) && !mask_full && (tmo_cnt == 10'(TMO - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else if (enable) begin
            if (state == S_IDLE && bus.rd_data_rdy) timeout_err <= 1'b0;
            if (state == S_LOAD)      tmo_cnt <= '0;
            else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 10'd1;
            // Missing lanes keep their cleared (zero) result value.
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Unused lanes of the last line read as zero through the padding.
    always_comb begin
        result_pad                 = '0;
        result_pad[LANES*DW-1:0]   = result_q;
        bus.wt_data                = '0;
        for (int k = 0; k < NLINES; k++) begin
            if (line == LW'(k)) bus.wt_data = result_pad[k*MEM_W +: MEM_W];
        end
    end

    assign bus.wt_line     = line;
    assign bus.div_operand = operand_q;
endmodule
